// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// error codes reported on o_err_code, and the default frame delimiter.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_OVR = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame parser: DEPTH x 8 simple dual-port storage
// with a synchronous write port and a registered, enable-gated read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value while rd_en is low, which keeps the
    // presented payload byte stable during consumer back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK with an
// XOR checksum, payload drained on valid/ready. Define UART_FRAME_PARSER_TIMEOUT_EN
// to abort stalled frames after TIMEOUT_CYCLES without a byte.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_reset_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_en,
    output logic [7:0] o_payload_data,
    output logic       o_payload_valid,
    input  logic       i_payload_ready,
    output logic       o_payload_last,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_frame_len,
    output logic       o_busy
);

    localparam int CW  = $clog2(MAX_LEN + 1);
    localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           state;
    logic [7:0]       len_reg;
    logic [7:0]       xor_acc;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    rd;

    logic [CW-1:0]    rd_inc;
    logic             accept;
    logic             rd_at_last;
    logic             idx_at_last;
    logic             sync_seen;
    logic             tmo_hit;

    logic             buf_wr_en;
    logic             buf_rd_en;
    logic [BAW-1:0]   buf_rd_addr;

    assign rd_inc      = rd + CW'(1);
    assign accept      = o_payload_valid && i_payload_ready;
    assign rd_at_last  = (8'(rd) == (len_reg - 8'd1));
    assign idx_at_last = (8'(idx) == (len_reg - 8'd1));
    assign sync_seen   = i_byte_en && (i_byte == SYNC_BYTE);
    assign o_busy      = (state != ST_IDLE);
    assign buf_wr_en   = (state == ST_PAYLOAD) && i_byte_en;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          in_frame;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    // Counting starts the cycle after a strobe, so matching TIMEOUT_CYCLES-2
    // lands the registered pulse exactly TIMEOUT_CYCLES cycles after it.
    assign tmo_hit  = in_frame && !i_byte_en && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tmo_cnt <= '0;
        end else if (i_byte_en || !in_frame || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        buf_rd_en   = 1'b0;
        buf_rd_addr = BAW'(rd);
        if (state == ST_DRAIN) begin
            if (!o_payload_valid) begin
                buf_rd_en = 1'b1;
            end else if (accept && !rd_at_last) begin
                buf_rd_en   = 1'b1;
                buf_rd_addr = BAW'(rd_inc);
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BAW)
    ) u_buf (
        .clk     (sys_clk),
        .rst_n   (sys_reset_n),
        .wr_en   (buf_wr_en),
        .wr_addr (BAW'(idx)),
        .wr_data (i_byte),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (o_payload_data)
    );

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state           <= ST_IDLE;
            len_reg         <= 8'h00;
            xor_acc         <= 8'h00;
            idx             <= '0;
            rd              <= '0;
            o_payload_valid <= 1'b0;
            o_payload_last  <= 1'b0;
            o_frame_ok      <= 1'b0;
            o_frame_err     <= 1'b0;
            o_err_code      <= 2'd0;
            o_frame_len     <= 8'h00;
        end else begin
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            if (tmo_hit) begin
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_TMO;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sync_seen) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (i_byte_en) begin
                            if (i_byte == 8'h00) begin
                                len_reg <= i_byte;
                                xor_acc <= 8'h00;
                                state   <= ST_CHK;
                            end else if (i_byte <= 8'(MAX_LEN)) begin
                                len_reg <= i_byte;
                                xor_acc <= i_byte;
                                idx     <= '0;
                                state   <= ST_PAYLOAD;
                            end else begin
                                o_frame_err <= 1'b1;
                                o_err_code  <= ERR_LEN;
                                state       <= ST_IDLE;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (i_byte_en) begin
                            xor_acc <= xor_acc ^ i_byte;
                            idx     <= idx + CW'(1);
                            if (idx_at_last) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (i_byte_en) begin
                            if (i_byte == xor_acc) begin
                                o_frame_ok  <= 1'b1;
                                o_frame_len <= len_reg;
                                rd          <= '0;
                                state       <= (len_reg == 8'h00) ? ST_IDLE : ST_DRAIN;
                            end else begin
                                o_frame_err <= 1'b1;
                                o_err_code  <= ERR_CHK;
                                state       <= ST_IDLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // The first drain cycle only primes the read register;
                        // a byte arriving as the last one is taken is IDLE input.
                        if (!o_payload_valid) begin
                            o_payload_valid <= 1'b1;
                            o_payload_last  <= (len_reg == 8'd1);
                        end else if (accept) begin
                            if (rd_at_last) begin
                                o_payload_valid <= 1'b0;
                                o_payload_last  <= 1'b0;
                                state           <= sync_seen ? ST_LEN : ST_IDLE;
                            end else begin
                                rd             <= rd_inc;
                                o_payload_last <= (8'(rd_inc) == (len_reg - 8'd1));
                            end
                        end
                        if (i_byte_en && !(accept && rd_at_last)) begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= ERR_OVR;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser; the timeout steps run
// only when UART_FRAME_PARSER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 20).
module tb_uart_frame_parser;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_en = 1'b0;
    logic        i_payload_ready = 1'b0;
    logic [7:0]  o_payload_data;
    logic        o_payload_valid;
    logic        o_payload_last;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [1:0]  o_err_code;
    logic [7:0]  o_frame_len;
    logic        o_busy;

    logic [22:0] all_outs;
    int          vectors = 0;
    int          miscompares = 0;
    int          seen_cycle;
    int          err_pulses;
    logic [1:0]  seen_code;

    assign all_outs = {o_payload_data, o_payload_valid, o_payload_last, o_frame_ok,
                       o_frame_err, o_err_code, o_frame_len, o_busy};

    uart_frame_parser #(
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_reset_n     (sys_reset_n),
        .i_byte          (i_byte),
        .i_byte_en       (i_byte_en),
        .o_payload_data  (o_payload_data),
        .o_payload_valid (o_payload_valid),
        .i_payload_ready (i_payload_ready),
        .o_payload_last  (o_payload_last),
        .o_frame_ok      (o_frame_ok),
        .o_frame_err     (o_frame_err),
        .o_err_code      (o_err_code),
        .o_frame_len     (o_frame_len),
        .o_busy          (o_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_byte    = b;
        i_byte_en = 1'b1;
        tick();
        i_byte_en = 1'b0;
    endtask

    // CHK values below are LEN xor all payload bytes, computed by hand.
    initial begin
        i_payload_ready = 1'b1;
        #2;
        check("reset_outputs", 32'(all_outs), 32'd0);
        tick();
        sys_reset_n = 1'b1;
        tick();

        // Good 3-byte frame: CHK = 03^11^22^33 = 03.
        send(8'hA5);
        check("t1_busy_after_sync", 32'(o_busy), 32'd1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        check("t1_ok", 32'({o_frame_ok, o_frame_err, o_payload_valid}), 32'b100);
        check("t1_len", 32'(o_frame_len), 32'd3);
        tick();
        check("t1_byte0", 32'({o_frame_ok, o_payload_valid, o_payload_last, o_payload_data}), 32'({3'b010, 8'h11}));
        tick();
        check("t1_byte1", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b10, 8'h22}));
        tick();
        check("t1_byte2", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b11, 8'h33}));
        tick();
        check("t1_idle", 32'({o_payload_valid, o_busy}), 32'b00);

        // Same frame with a bad checksum, then a good 1-byte frame (CHK 01^7E = 7F).
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h01);
        check("t2_chk_err", 32'({o_frame_ok, o_frame_err, o_err_code}), 32'b0100);
        tick();
        check("t2_idle", 32'({o_payload_valid, o_busy, o_frame_err}), 32'b000);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        check("t2_ok", 32'({o_frame_ok, o_frame_len}), 32'({1'b1, 8'd1}));
        tick();
        check("t2_payload", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b11, 8'h7E}));

        // Oversized LEN, then recovery on the following bytes.
        tick();
        send(8'hA5); send(8'h11);
        check("t3_len_err", 32'({o_frame_ok, o_frame_err, o_err_code, o_busy}), 32'b01010);
        send(8'h00); send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        check("t3_ok", 32'({o_frame_ok, o_frame_err, o_frame_len}), 32'({2'b10, 8'd1}));
        tick();
        check("t3_payload", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b11, 8'h7E}));
        tick();
        check("t3_done", 32'({o_payload_valid, o_busy}), 32'b00);

        // 2-byte frame stalled by the consumer; CHK = 02^C3^3C = FD.
        i_payload_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
        check("t4_ok", 32'({o_frame_ok, o_frame_len}), 32'({1'b1, 8'd2}));
        tick();
        check("t4_first", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b10, 8'hC3}));
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                send(8'h55);
                check("t4_ovr_err", 32'({o_frame_ok, o_frame_err, o_err_code}), 32'b0110);
            end else begin
                tick();
            end
            check("t4_stall_hold", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b10, 8'hC3}));
        end
        i_payload_ready = 1'b1;
        tick();
        check("t4_second", 32'({o_payload_valid, o_payload_last, o_payload_data}), 32'({2'b11, 8'h3C}));
        // SYNC arriving as the last byte is accepted starts a new frame.
        send(8'hA5);
        check("t4_exit_sync", 32'({o_frame_err, o_payload_valid, o_busy}), 32'b001);

        // Zero-length frame continues from that SYNC, then ignored garbage.
        send(8'h00); send(8'h00);
        check("t5_ok", 32'({o_frame_ok, o_frame_err, o_frame_len, o_payload_valid}), 32'({2'b10, 8'd0, 1'b0}));
        tick();
        check("t5_idle", 32'({o_busy, o_payload_valid}), 32'b00);
        send(8'h12);
        check("t5_garbage0", 32'({o_frame_err, o_frame_ok, o_busy}), 32'b000);
        send(8'h34);
        check("t5_garbage1", 32'({o_frame_err, o_frame_ok, o_busy}), 32'b000);

        // Reset in the middle of a drain and of a payload.
        i_payload_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        tick();
        check("t6_drain_valid", 32'(o_payload_valid), 32'd1);
        sys_reset_n = 1'b0;
        #1;
        check("t6_reset_drain", 32'(all_outs), 32'd0);
        tick();
        sys_reset_n = 1'b1;
        i_payload_ready = 1'b1;
        send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
        sys_reset_n = 1'b0;
        #1;
        check("t6_reset_payload", 32'(all_outs), 32'd0);
        tick();
        sys_reset_n = 1'b1;
        tick();
        check("t6_after_reset", 32'(all_outs), 32'd0);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        seen_cycle = -1;
        seen_code  = 2'd0;
        send(8'hA5); send(8'h02); send(8'h11);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (o_frame_err && (seen_cycle < 0)) begin
                seen_cycle = i + 1;
                seen_code  = o_err_code;
            end
        end
        check("t7_tmo_cycle", 32'(seen_cycle), 32'd20);
        check("t7_tmo_code", 32'(seen_code), 32'd3);
        check("t7_tmo_idle", 32'(o_busy), 32'd0);

        err_pulses = 0;
        send(8'hA5); send(8'h02); send(8'h11);
        tick();
        sys_reset_n = 1'b0;
        #1;
        check("t7_reset_outputs", 32'(all_outs), 32'd0);
        tick();
        sys_reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_frame_err) err_pulses++;
        end
        check("t7_no_pulse_after_reset", 32'(err_pulses), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
